// File: rtl/psum_ofifo.sv
// rtl/psum_ofifo.sv - south-edge partial-sum collector: per-column lane FIFOs realigned into full rows
// A row pops only when every lane holds an entry; all lanes share one read pointer.
module psum_ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2*psum_bw*col-1:0]   in,
  input  logic [col-1:0]             wr,
  input  logic                       rd,
  output logic [2*psum_bw*col-1:0]   out,
  output logic                       o_valid,
  output logic                       o_full,
  output logic                       o_ready,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int LW = 2 * psum_bw;
  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;

  logic [LW-1:0]     mem_q [col][depth];
  logic [PW-1:0]     wptr_q [col];
  logic [PW-1:0]     wptr_d [col];
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [LW*col-1:0] out_q, out_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [col-1:0]    lane_empty, lane_full, wr_en;
  logic              rd_en;

  // Status is taken from pre-edge pointers: no write-through into a full lane, no bypass on an empty one.
  always_comb begin
    lane_empty = '0;
    lane_full  = '0;
    wr_en      = '0;
    for (int i = 0; i < col; i++) begin
      lane_empty[i] = (wptr_q[i] == rptr_q);
      lane_full[i]  = (wptr_q[i][AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[i][AW] != rptr_q[AW]);
      wr_en[i]      = wr[i] & ~lane_full[i];
    end
  end

  assign o_valid   = ~|lane_empty;
  assign o_full    = |lane_full;
  assign o_ready   = ~o_full;
  assign out       = out_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    rd_en       = rd & o_valid;
    rptr_d      = rptr_q + {{AW{1'b0}}, rd_en};
    out_d       = out_q;
    for (int i = 0; i < col; i++) begin
      wptr_d[i] = wptr_q[i] + {{AW{1'b0}}, wr_en[i]};
      if (rd_en) begin
        out_d[i*LW +: LW] = mem_q[i][rptr_q[AW-1:0]];
      end
    end
    overflow_d  = overflow_q | (|(wr & lane_full));
    underflow_d = underflow_q | (rd & ~o_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < col; i++) begin
        wptr_q[i] <= '0;
      end
      rptr_q      <= '0;
      out_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < col; i++) begin
        wptr_q[i] <= wptr_d[i];
      end
      rptr_q      <= rptr_d;
      out_q       <= out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < col; i++) begin
      if (wr_en[i]) begin
        mem_q[i][wptr_q[i][AW-1:0]] <= in[i*LW +: LW];
      end
    end
  end

endmodule

// File: tb/tb_psum_ofifo.sv
// tb/tb_psum_ofifo.sv - randomized self-checking bench for psum_ofifo against a queue-based lane model
module tb_psum_ofifo;

  localparam int COL   = 8;
  localparam int PBW   = 16;
  localparam int DEPTH = 64;
  localparam int RW    = 2 * PBW * COL;

  logic          clk;
  logic          reset;
  logic [RW-1:0] in_data;
  logic [COL-1:0] wr;
  logic          rd;
  logic [RW-1:0] dout;
  logic          o_valid, o_full, o_ready, overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]   lq [COL][$];
  logic [RW-1:0] m_out;
  logic          m_ovf, m_unf;

  psum_ofifo #(.col(COL), .psum_bw(PBW), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .in(in_data), .wr(wr), .rd(rd),
    .out(dout), .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_valid();
    for (int i = 0; i < COL; i++) if (lq[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_full();
    for (int i = 0; i < COL; i++) if (lq[i].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: drive inputs, update the model from pre-edge occupancy, settle past the edge.
  task automatic step(input logic rst, input logic [COL-1:0] w, input logic [RW-1:0] d, input logic r);
    logic pre_valid;
    logic pre_full [COL];
    reset = rst; wr = w; in_data = d; rd = r;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < COL; i++) lq[i].delete();
      m_out = '0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      pre_valid = m_valid();
      for (int i = 0; i < COL; i++) pre_full[i] = (lq[i].size() == DEPTH);
      for (int i = 0; i < COL; i++) begin
        if (w[i]) begin
          if (pre_full[i]) m_ovf = 1'b1;
          else lq[i].push_back(d[i*32 +: 32]);
        end
      end
      if (r) begin
        if (pre_valid) for (int i = 0; i < COL; i++) m_out[i*32 +: 32] = lq[i].pop_front();
        else m_unf = 1'b1;
      end
    end
    #1;
    reset = 1'b0; wr = '0; rd = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, '1, rand_row(), 1'b1);
    step(1'b1, '1, rand_row(), 1'b1);
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_out got %h exp 0", dout); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", o_valid); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", o_ready); end
    n_checks++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", o_full); end
    n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b exp 00", overflow, underflow); end
    step(1'b0, '0, '0, 1'b0);
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_nowrite got valid %b exp 0", o_valid); end
  endtask

  task automatic test_staggered();
    logic [RW-1:0] d;
    logic [31:0]   e;
    for (int i = 0; i < COL; i++) begin
      d = '0;
      e = 32'h0001_0000 * i + 5;
      d[i*32 +: 32] = e;
      step(1'b0, COL'(1) << i, d, 1'b0);
      n_checks++;
      if (o_valid !== (i == COL - 1)) begin n_fail++; $display("FAIL stagger_valid i=%0d got %b exp %b", i, o_valid, (i == COL - 1)); end
    end
    step(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < COL; i++) begin
      e = 32'h0001_0000 * i + 5;
      n_checks++;
      if (dout[i*32 +: 32] !== e) begin n_fail++; $display("FAIL stagger_out lane=%0d got %h exp %h", i, dout[i*32 +: 32], e); end
    end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL stagger_drop got %b exp 0", o_valid); end
  endtask

  task automatic test_lane_full();
    logic [31:0] lane0 [DEPTH];
    logic [RW-1:0] d;
    step(1'b1, '0, '0, 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      d = rand_row();
      lane0[k] = d[31:0];
      step(1'b0, COL'(1), d, 1'b0);
    end
    n_checks++; if (o_full !== 1'b1 || o_ready !== 1'b0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL full_status got f%b r%b v%b exp f1 r0 v0", o_full, o_ready, o_valid); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_noovf got %b exp 0", overflow); end
    step(1'b0, COL'(1), rand_row(), 1'b0);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_ovf got %b exp 1", overflow); end
    for (int k = 0; k < DEPTH; k++) step(1'b0, {{(COL-1){1'b1}}, 1'b0}, rand_row(), 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b0, '0, '0, 1'b1);
      n_checks++;
      if (dout[31:0] !== lane0[k]) begin n_fail++; $display("FAIL full_lane0 k=%0d got %h exp %h", k, dout[31:0], lane0[k]); end
      n_checks++;
      if (dout !== m_out) begin n_fail++; $display("FAIL full_row k=%0d got %h exp %h", k, dout, m_out); end
    end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained got %b exp 0", o_valid); end
  endtask

  task automatic test_underflow();
    step(1'b1, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_set got %b exp 1", underflow); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL unf_out got %h exp 0", dout); end
    step(1'b0, '1, rand_row(), 1'b0);
    step(1'b0, '0, '0, 1'b1);
    n_checks++; if (dout !== m_out) begin n_fail++; $display("FAIL unf_row got %h exp %h", dout, m_out); end
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_sticky got %b exp 1", underflow); end
  endtask

  task automatic test_wrap_stream();
    logic [RW-1:0] d;
    logic [31:0]   e;
    step(1'b1, '0, '0, 1'b0);
    for (int r = 0; r <= 2 * DEPTH + 3; r++) begin
      for (int i = 0; i < COL; i++) d[i*32 +: 32] = {16'(r), 16'(i)};
      step(1'b0, (r < 2 * DEPTH + 3) ? '1 : '0, d, r > 0);
      if (r > 0) begin
        for (int i = 0; i < COL; i++) begin
          e = {16'(r - 1), 16'(i)};
          n_checks++;
          if (dout[i*32 +: 32] !== e) begin n_fail++; $display("FAIL wrap_out r=%0d lane=%0d got %h exp %h", r, i, dout[i*32 +: 32], e); end
        end
      end
    end
    n_checks++; if (o_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL wrap_end got v%b o%b u%b exp 000", o_valid, overflow, underflow); end
    for (int k = 0; k < DEPTH; k++) step(1'b0, '1, rand_row(), 1'b0);
    n_checks++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL wrap_full got %b exp 1", o_full); end
    step(1'b0, '1, rand_row(), 1'b1);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL rdwr_ovf got %b exp 1", overflow); end
    n_checks++; if (dout !== m_out) begin n_fail++; $display("FAIL rdwr_out got %h exp %h", dout, m_out); end
    n_checks++; if (o_full !== 1'b0 || o_valid !== 1'b1) begin n_fail++; $display("FAIL rdwr_status got f%b v%b exp f0 v1", o_full, o_valid); end
  endtask

  task automatic test_random();
    logic [COL-1:0] w;
    logic r;
    step(1'b1, '0, '0, 1'b0);
    for (int c = 0; c < 400; c++) begin
      w = COL'($urandom);
      r = ($urandom_range(0, 99) < 45);
      step(1'b0, w, rand_row(), r);
      n_checks++;
      if (dout !== m_out || o_valid !== m_valid() || o_full !== m_full() || o_ready !== ~m_full() ||
          overflow !== m_ovf || underflow !== m_unf) begin
        n_fail++;
        $display("FAIL random c=%0d got v%b f%b r%b o%b u%b out %h exp v%b f%b o%b u%b out %h", c, o_valid, o_full, o_ready,
                 overflow, underflow, dout, m_valid(), m_full(), m_ovf, m_unf, m_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, '0, '0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, '1, rand_row(), 1'b0);
    step(1'b0, '0, '0, 1'b1);
    step(1'b1, '0, '0, 1'b1);
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b exp 0", o_valid); end
    n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL mid_flags got %b%b exp 00", overflow, underflow); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL mid_out got %h exp 0", dout); end
    step(1'b0, '1, rand_row(), 1'b0);
    step(1'b0, '0, '0, 1'b1);
    n_checks++; if (dout !== m_out || o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_row got %h v%b exp %h v0", dout, o_valid, m_out); end
  endtask

  initial begin
    reset = 1'b0; wr = '0; rd = 1'b0; in_data = '0;
    m_out = '0; m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk);
    test_reset();
    test_staggered();
    test_lane_full();
    test_underflow();
    test_wrap_stream();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
